// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus once each pattern holds steady.
// Optional macro SEG7_SCAN_DEC_ERRCNT_EN adds an 8-bit saturating unrecognised-pattern counter.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 5,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   an_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   blank_o,
  output logic [NUM_DIGITS-1:0]   valid_o,
  output logic                    update_o,
  output logic                    err_o
`ifdef SEG7_SCAN_DEC_ERRCNT_EN
  ,
  output logic [7:0]              err_count_o
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  state_t                        state_q, state_d;
  logic [6:0]                    seg_q, pat_q, pat_d;
  logic [NUM_DIGITS-1:0]         an_q;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [KW-1:0]                 k_q, k_d, sel_k;
  logic [3:0]                    zeros;
  logic                          legal, same, start, capture;
  logic [NUM_DIGITS-1:0][3:0]    dig_q;
  logic [4:0]                    dec;

  // Returns {recognised, nibble}; blank is handled separately.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0011000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    sel_k = '0;
    zeros = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        sel_k = KW'(i);
        zeros = zeros + 4'd1;
      end
    end
    legal = (zeros == 4'd1);
    same  = (sel_k == k_q) && (seg_q == pat_q);
    dec   = decode(seg_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    pat_d   = pat_q;
    start   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: start = legal;
      SETTLE: begin
        if (!legal) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          start = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
          if (cnt_d == STABLE_C) begin
            capture = 1'b1;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (!legal) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          start = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // A fresh pattern counts as its first stable cycle, so STABLE_CYCLES=1 captures here.
    if (start) begin
      k_d   = sel_k;
      pat_d = seg_q;
      cnt_d = ONE_C;
      if (STABLE_C == ONE_C) begin
        capture = 1'b1;
        state_d = LOCKED;
      end else begin
        state_d = SETTLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seg_q   <= '0;
      an_q    <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      pat_q   <= '0;
    end else begin
      seg_q   <= seg_i;
      an_q    <= an_i;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      pat_q   <= pat_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dig_q       <= '0;
      blank_o     <= '1;
      valid_o     <= '0;
      update_o    <= 1'b0;
      err_o       <= 1'b0;
`ifdef SEG7_SCAN_DEC_ERRCNT_EN
      err_count_o <= '0;
`endif
    end else begin
      update_o <= 1'b0;
      if (capture) begin
        if (seg_q == 7'b1111111) begin
          valid_o[sel_k] <= 1'b1;
          blank_o[sel_k] <= 1'b1;
          update_o       <= !blank_o[sel_k];
        end else if (dec[4]) begin
          valid_o[sel_k] <= 1'b1;
          blank_o[sel_k] <= 1'b0;
          dig_q[sel_k]   <= dec[3:0];
          update_o       <= blank_o[sel_k] || (dig_q[sel_k] != dec[3:0]);
        end else begin
          err_o <= 1'b1;
`ifdef SEG7_SCAN_DEC_ERRCNT_EN
          if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
`endif
        end
      end
    end
  end

  assign digits_o = dig_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed and random bus traffic checked every cycle
// against a run-length reference model of the displayed digits.
module tb_seg7_scan_decoder;

  localparam int N = 5;
  localparam int S = 4;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic [6:0]     seg_i = 7'h7f;
  logic [N-1:0]   an_i  = '1;
  logic [4*N-1:0] digits_o;
  logic [N-1:0]   blank_o, valid_o;
  logic           update_o, err_o;
`ifdef SEG7_SCAN_DEC_ERRCNT_EN
  logic [7:0]     err_count_o;
`endif

  seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .seg_i(seg_i), .an_i(an_i),
    .digits_o(digits_o), .blank_o(blank_o), .valid_o(valid_o),
    .update_o(update_o), .err_o(err_o)
`ifdef SEG7_SCAN_DEC_ERRCNT_EN
    , .err_count_o(err_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [6:0] pat_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference state: per-digit values plus the length of the current identical legal run.
  logic [3:0]   m_dig [N];
  logic [N-1:0] m_blank, m_valid;
  logic         m_upd, m_err;
  int           m_cnt;
  int           run;
  logic [N-1:0] last_an, prev_an;
  logic [6:0]   last_seg, prev_seg;

  function automatic logic [4*N-1:0] m_digits();
    logic [4*N-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = m_dig[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".digits"}, 64'(digits_o), 64'(m_digits()));
    chk({tag, ".blank"},  64'(blank_o),  64'(m_blank));
    chk({tag, ".valid"},  64'(valid_o),  64'(m_valid));
    chk({tag, ".update"}, 64'(update_o), 64'(m_upd));
    chk({tag, ".err"},    64'(err_o),    64'(m_err));
`ifdef SEG7_SCAN_DEC_ERRCNT_EN
    chk({tag, ".errcnt"}, 64'(err_count_o), 64'(m_cnt));
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_dig[i] = 4'h0;
    m_blank = '1; m_valid = '0; m_upd = 1'b0; m_err = 1'b0; m_cnt = 0;
    run = 0; last_an = '0; last_seg = '0; prev_an = '0; prev_seg = '0;
  endtask

  // A digit is captured when a legal (an, seg) pair has been seen exactly S times in a row.
  task automatic model_cycle(input logic [N-1:0] an, input logic [6:0] seg);
    int k, ones, nib;
    ones = 0; k = 0;
    for (int i = 0; i < N; i++) if (!an[i]) begin ones++; k = i; end
    if (ones != 1) run = 0;
    else if (run > 0 && an == last_an && seg == last_seg) run++;
    else run = 1;
    last_an = an; last_seg = seg;
    m_upd = 1'b0;
    if (ones == 1 && run == S) begin
      nib = -1;
      for (int j = 0; j < 16; j++) if (pat_tbl[j] == seg) nib = j;
      if (seg == 7'b1111111) begin
        m_upd = !m_blank[k];
        m_blank[k] = 1'b1; m_valid[k] = 1'b1;
      end else if (nib >= 0) begin
        m_upd = m_blank[k] || (m_dig[k] != 4'(nib));
        m_dig[k] = 4'(nib); m_blank[k] = 1'b0; m_valid[k] = 1'b1;
      end else begin
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] an, input logic [6:0] seg, input string tag);
    an_i = an; seg_i = seg;
    @(posedge clk_i); #1;
    model_cycle(prev_an, prev_seg);
    prev_an = an; prev_seg = seg;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1; #1;
    model_reset();
    chk_all(tag);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  function automatic logic [N-1:0] sel(input int k);
    return ~(N'(1) << k);
  endfunction

  initial begin
    logic [N-1:0] r_an;
    logic [6:0]   r_seg;
    int           hold;

    do_reset("reset");
    for (int i = 0; i < 20; i++) step('1, 7'b1111111, "idle");

    // Digit 0 shows "3": pulse appears on the fifth clock only.
    for (int i = 0; i < 4; i++) step(sel(0), 7'b0110000, "hold3");
    chk("no_pulse_c4", 64'(update_o), 64'd0);
    step(sel(0), 7'b0110000, "hold3");
    chk("pulse_c5", 64'(update_o), 64'd1);
    chk("dig0_is_3", 64'(digits_o[3:0]), 64'd3);
    for (int i = 0; i < 50; i++) step(sel(0), 7'b0110000, "hold3_long");

    // Scan five digits.
    for (int i = 0; i < 6; i++) step(sel(0), 7'b0000010, "scan0");
    for (int i = 0; i < 6; i++) step(sel(1), 7'b0100001, "scan1");
    for (int i = 0; i < 6; i++) step(sel(2), 7'b1111111, "scan2");
    for (int i = 0; i < 6; i++) step(sel(3), 7'b0001110, "scan3");
    for (int i = 0; i < 6; i++) step(sel(4), 7'b1000000, "scan4");
    step('1, 7'b1111111, "scan_end");
    chk("scan_digits", 64'(digits_o), 64'h0F0D6);
    chk("scan_blank",  64'(blank_o),  64'b00100);
    chk("scan_valid",  64'(valid_o),  64'b11111);

    // Toggling digit 1 faster than the dwell never captures.
    do_reset("reset2");
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 3; j++)
        step(sel(1), (i % 2) ? 7'b1111001 : 7'b0100100, "toggle");
    chk("toggle_valid1", 64'(valid_o[1]), 64'd0);

    // Unrecognised pattern sets sticky err, repeated to saturate the counter.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < S; i++) step(sel(2), 7'b1010101, "bad");
      step('1, 7'b1111111, "bad_gap");
    end
    chk("err_sticky", 64'(err_o), 64'd1);
    chk("err_no_valid2", 64'(valid_o[2]), 64'd0);
`ifdef SEG7_SCAN_DEC_ERRCNT_EN
    chk("errcnt_sat", 64'(err_count_o), 64'd255);
`endif

    // Reset while settling, then a full dwell is needed again.
    do_reset("reset3");
    for (int i = 0; i < 3; i++) step(sel(0), 7'b0011001, "pre_rst");
    do_reset("mid_reset");
    chk("mid_reset_valid", 64'(valid_o), 64'd0);
    for (int i = 0; i < S; i++) step(sel(0), 7'b0011001, "post_rst");
    chk("post_rst_not_yet", 64'(valid_o[0]), 64'd0);
    step(sel(0), 7'b0011001, "post_rst");
    chk("post_rst_capture", 64'(valid_o[0]), 64'd1);
    chk("post_rst_dig", 64'(digits_o[3:0]), 64'd4);

    // Random traffic: mostly legal selects with table, blank or garbage patterns.
    for (int n = 0; n < 300; n++) begin
      r_an = ($urandom_range(0, 7) == 0) ? N'($urandom) : sel($urandom_range(0, N-1));
      case ($urandom_range(0, 9))
        0:       r_seg = 7'b1111111;
        1:       r_seg = 7'($urandom);
        default: r_seg = pat_tbl[$urandom_range(0, 15)];
      endcase
      hold = $urandom_range(1, 7);
      for (int i = 0; i < hold; i++) step(r_an, r_seg, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Monitor block that watches a multiplexed, active-low 7-segment display bus (segment lines plus digit anodes) and recovers the displayed hex digit for each position. It is the reverse of the hex-to-segment encoder. It lets the 5-digit timer self-check its display path and gives the testbench and debug logic a readable digit value. Each digit is captured only after its pattern has held stable for a programmable dwell time.

Parameters:
NUM_DIGITS, 5, number of multiplexed digit positions (anode width); 1..8
STABLE_CYCLES, 4, consecutive identical cycles required before capture; >=1

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
seg_i  input  7  segment bus, bit order 6543210 (g..a), active-low
an_i  input  NUM_DIGITS  digit select, one-hot active-low (bit k low = digit k lit)
digits_o  output  4*NUM_DIGITS  captured nibble per digit; digit k at [4k+3:4k]
blank_o  output  NUM_DIGITS  1 = digit k last captured blank (seg 1111111)
valid_o  output  NUM_DIGITS  1 = digit k captured at least once since reset
update_o  output  1  one-cycle pulse when any digit's nibble or blank bit changes
err_o  output  1  sticky: an unrecognised non-blank pattern was captured

Behaviour:
- Reset (asynchronous, rst_i=1): digits_o=0, blank_o=all 1, valid_o=0, update_o=0, err_o=0, FSM=IDLE, counter=0, sample registers=0.
- Sampling: seg_i and an_i are registered once every cycle (sample stage). The FSM operates on the registered values only.
- an_i is "legal" when exactly one bit is 0. The selected index is k.
- FSM states:
  - IDLE: an illegal -> stay. Legal -> SETTLE, cnt=1, latch k and pattern.
  - SETTLE: an illegal -> IDLE. k or pattern differs from latched -> restart SETTLE with cnt=1 and the new values. Same -> cnt+1. Reaching cnt==STABLE_CYCLES -> capture, then go to LOCKED.
  - LOCKED: same k and pattern -> stay; no re-capture. Any change -> IDLE if illegal, else SETTLE with cnt=1.
- STABLE_CYCLES=1: capture occurs on the first registered legal cycle.
- Counter width: clog2(STABLE_CYCLES+1). The counter never wraps.
- Capture decode for digit k (pattern -> nibble):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0011000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F
  - 1111111 = blank: blank_o[k]=1, nibble unchanged.
  - Recognised hex pattern: nibble written, blank_o[k]=0.
  - valid_o[k] is set by any recognised or blank capture.
  - Any other pattern: err_o=1 (sticky until reset); digits_o, blank_o and valid_o for digit k are unchanged.
- Output timing: all outputs are registered. A capture is visible on the cycle after the capture cycle. End-to-end latency from a stable bus change is STABLE_CYCLES+1 clocks.
- update_o: high for exactly one cycle when a capture changes digits_o[k] or blank_o[k]. Re-capturing an identical value gives no pulse. Unrecognised captures give no pulse.
- Mid-operation reset: all state clears immediately; no partial capture survives.

Optional Feature:
- Macro SEG7_SCAN_DEC_ERRCNT_EN.
- Defined: adds output port err_count_o (8 bits). It is an 8-bit counter that increments on each unrecognised capture, saturates at 255, and resets to 0. err_o behaves as without the macro.
- Undefined: the port and counter are absent. err_o is the only error indication.

Test Plan:
- Reset, an_i=11111 for 20 cycles -> blank_o=11111, valid_o=0, digits_o=0, update_o never high.
- an_i=11110, seg_i=0110000 held 4 cycles -> valid_o[0]=1, digits_o[3:0]=3, update_o one pulse at cycle 5; holding 50 more cycles gives no further pulse.
- Scan digits 0..4 with 0000010, 0100001, 1111111, 0001110, 1000000, 6 cycles each -> digits_o nibbles 6, D, 0, F, 0 (digit 0 in nibble 0); blank_o=00100; valid_o=11111.
- Digit 1 pattern toggles every 3 cycles with STABLE_CYCLES=4 -> no capture, valid_o[1]=0, no update_o.
- Digit 2 shows 1010101 for 4 cycles -> err_o=1 and stays 1; digits_o/blank_o unchanged; with macro, err_count_o=1, and after 300 such captures err_count_o=255.
- Assert rst_i during SETTLE on digit 0 -> outputs return to reset values at once; after release, capture needs a full STABLE_CYCLES again.
